// File: rtl/ddr4_writer_state_params.sv
// Writes the final Kalman state vector and covariance back to DDR4, one single-beat
// 512-bit AXI write per 64-byte beat: X beats first, then P beats in row-major order.
module ddr4_writer_state_params #(
  parameter int unsigned STATE_DIM   = 12,
  parameter logic [31:0] ADDR_X_BASE = 32'h0050_0000,
  parameter logic [31:0] ADDR_P_BASE = 32'h0060_0000
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [STATE_DIM-1:0][63:0]              X_in,
  input  logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0] P_in,
  output logic [31:0]                             axi_awaddr,
  output logic [7:0]                              axi_awlen,
  output logic [2:0]                              axi_awsize,
  output logic [1:0]                              axi_awburst,
  output logic                                    axi_awvalid,
  input  logic                                    axi_awready,
  output logic [511:0]                            axi_wdata,
  output logic [63:0]                             axi_wstrb,
  output logic                                    axi_wlast,
  output logic                                    axi_wvalid,
  input  logic                                    axi_wready,
  input  logic [1:0]                              axi_bresp,
  input  logic                                    axi_bvalid,
  output logic                                    axi_bready,
  output logic                                    write_done,
  output logic                                    write_error
);

  localparam int unsigned X_BEATS  = (STATE_DIM + 7) / 8;
  localparam int unsigned P_BEATS  = (STATE_DIM * STATE_DIM + 7) / 8;
  localparam int unsigned MAX_BEAT = (P_BEATS > X_BEATS) ? P_BEATS : X_BEATS;
  localparam int unsigned BEAT_W   = $clog2(MAX_BEAT + 1);

  typedef logic [STATE_DIM-1:0][63:0]                x_vec_t;
  typedef logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0] p_mat_t;
  typedef enum logic [1:0] {StIdle, StXfer, StResp, StDone} state_e;

  // Lane i of a beat carries linear element beat*8+i; lanes past the end stay zero.
  function automatic logic [511:0] beat_data(input logic is_p, input logic [BEAT_W-1:0] beat,
                                             input x_vec_t x, input p_mat_t p);
    logic [7:0][63:0] d;
    d = '0;
    if (!is_p) begin
      for (int e = 0; e < int'(STATE_DIM); e++) begin
        if (e / 8 == int'(beat)) d[e % 8] = x[e];
      end
    end else begin
      for (int r = 0; r < int'(STATE_DIM); r++) begin
        for (int c = 0; c < int'(STATE_DIM); c++) begin
          if ((r * int'(STATE_DIM) + c) / 8 == int'(beat)) begin
            d[(r * int'(STATE_DIM) + c) % 8] = p[r][c];
          end
        end
      end
    end
    return d;
  endfunction

  function automatic logic [63:0] beat_strb(input logic is_p, input logic [BEAT_W-1:0] beat);
    logic [7:0][7:0] s;
    int              lin;
    int              total;
    s     = '0;
    total = is_p ? int'(STATE_DIM * STATE_DIM) : int'(STATE_DIM);
    for (int i = 0; i < 8; i++) begin
      lin = int'(beat) * 8 + i;
      if (lin < total) s[i] = 8'hFF;
    end
    return s;
  endfunction

  state_e              state_q, state_d;
  x_vec_t              x_snap_q, x_snap_d;
  p_mat_t              p_snap_q, p_snap_d;
  logic                is_p_q, is_p_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic [31:0]         awaddr_q, awaddr_d;
  logic [511:0]        wdata_q, wdata_d;
  logic [63:0]         wstrb_q, wstrb_d;
  logic                err_q, err_d;
  logic                nxt_is_p;
  logic [BEAT_W-1:0]   nxt_beat;

  always_comb begin
    state_d   = state_q;
    x_snap_d  = x_snap_q;
    p_snap_d  = p_snap_q;
    is_p_d    = is_p_q;
    beat_d    = beat_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    err_d     = err_q;
    nxt_is_p  = is_p_q;
    nxt_beat  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Beat 0 is built from the live inputs since the snapshot lands this same edge.
          x_snap_d  = X_in;
          p_snap_d  = P_in;
          err_d     = 1'b0;
          is_p_d    = 1'b0;
          beat_d    = '0;
          awaddr_d  = ADDR_X_BASE;
          wdata_d   = beat_data(1'b0, '0, X_in, P_in);
          wstrb_d   = beat_strb(1'b0, '0);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (awvalid_q && axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = StResp;
      end
      StResp: begin
        if (axi_bvalid) begin
          if (axi_bresp != 2'b00) err_d = 1'b1;
          if (is_p_q && beat_q == BEAT_W'(P_BEATS - 1)) begin
            state_d = StDone;
          end else begin
            if (!is_p_q && beat_q == BEAT_W'(X_BEATS - 1)) begin
              nxt_is_p = 1'b1;
              nxt_beat = '0;
            end else begin
              nxt_beat = beat_q + 1'b1;
            end
            is_p_d    = nxt_is_p;
            beat_d    = nxt_beat;
            awaddr_d  = (nxt_is_p ? ADDR_P_BASE : ADDR_X_BASE) + (32'(nxt_beat) << 6);
            wdata_d   = beat_data(nxt_is_p, nxt_beat, x_snap_q, p_snap_q);
            wstrb_d   = beat_strb(nxt_is_p, nxt_beat);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StXfer;
          end
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_p_q    <= 1'b0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_p_q    <= is_p_d;
      beat_q    <= beat_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      err_q     <= err_d;
    end
  end

  // Snapshot needs no reset: it is always loaded before being read.
  always_ff @(posedge clk) begin
    x_snap_q <= x_snap_d;
    p_snap_q <= p_snap_d;
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'b110;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = (state_q == StResp);
  assign write_done  = (state_q == StDone);
  assign write_error = err_q;

endmodule

// File: tb/tb_ddr4_writer_state_params.sv
// Directed bench for ddr4_writer_state_params: AXI slave with programmable ready delays
// and error injection, handshake log, and a formula model of the expected beats.
module tb_ddr4_writer_state_params;

  localparam int unsigned SD = 12;
  localparam int          NB = 20;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start;
  logic [SD-1:0][63:0]        X_in;
  logic [SD-1:0][SD-1:0][63:0] P_in;
  logic [31:0]                axi_awaddr;
  logic [7:0]                 axi_awlen;
  logic [2:0]                 axi_awsize;
  logic [1:0]                 axi_awburst;
  logic                       axi_awvalid;
  logic                       axi_awready;
  logic [511:0]               axi_wdata;
  logic [63:0]                axi_wstrb;
  logic                       axi_wlast;
  logic                       axi_wvalid;
  logic                       axi_wready;
  logic [1:0]                 axi_bresp;
  logic                       axi_bvalid;
  logic                       axi_bready;
  logic                       write_done;
  logic                       write_error;

  always #5 clk = ~clk;

  ddr4_writer_state_params dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .X_in        (X_in),
    .P_in        (P_in),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .write_done  (write_done),
    .write_error (write_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: ready after a programmable number of wait cycles, response always valid.
  int unsigned aw_delay = 0, w_delay = 0, err_beat = 99;
  int unsigned aw_cnt, w_cnt, b_count;

  assign axi_awready = (aw_cnt >= aw_delay);
  assign axi_wready  = (w_cnt >= w_delay);
  assign axi_bvalid  = 1'b1;
  assign axi_bresp   = (b_count == err_beat) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt  <= 0;
      w_cnt   <= 0;
      b_count <= 0;
    end else begin
      if (axi_awvalid && axi_awready) aw_cnt <= 0;
      else if (axi_awvalid)           aw_cnt <= aw_cnt + 1;
      if (axi_wvalid && axi_wready)   w_cnt <= 0;
      else if (axi_wvalid)            w_cnt <= w_cnt + 1;
      if (axi_bvalid && axi_bready)   b_count <= b_count + 1;
    end
  end

  // Handshake log plus hold/stability and bready-ordering checks.
  logic [31:0]  aw_log[32];
  logic [511:0] w_log[32];
  logic [63:0]  s_log[32];
  int           n_aw, n_w;
  logic         aw_pend, w_pend;
  logic [31:0]  pend_addr;
  logic [511:0] pend_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_aw = 0; n_w = 0; aw_pend = 1'b0; w_pend = 1'b0;
    end else begin
      if (aw_pend) begin
        check_eq("aw_hold", axi_awvalid, 1);
        check_eq("aw_stable", axi_awaddr, pend_addr);
      end
      if (w_pend) begin
        check_eq("w_hold", axi_wvalid, 1);
        check_eq("w_stable", axi_wdata, pend_data);
      end
      if (axi_bready) check_eq("bready_after_both", {axi_awvalid, axi_wvalid}, 0);
      aw_pend   = axi_awvalid && !axi_awready;
      w_pend    = axi_wvalid && !axi_wready;
      pend_addr = axi_awaddr;
      pend_data = axi_wdata;
      if (axi_awvalid && axi_awready && n_aw < 32) begin
        aw_log[n_aw] = axi_awaddr;
        n_aw++;
      end
      if (axi_wvalid && axi_wready && n_w < 32) begin
        w_log[n_w] = axi_wdata;
        s_log[n_w] = axi_wstrb;
        n_w++;
      end
    end
  end

  // Model: X[k]=k+1, P[r][c]=r*16+c.
  function automatic logic [31:0] exp_addr(input int b);
    return (b < 2) ? 32'h0050_0000 + 32'(b * 64) : 32'h0060_0000 + 32'((b - 2) * 64);
  endfunction

  function automatic logic [511:0] exp_data(input int b);
    logic [511:0] d;
    int lin;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if (b < 2) begin
        lin = b * 8 + i;
        if (lin < 12) d[i*64 +: 64] = 64'(lin + 1);
      end else begin
        lin = (b - 2) * 8 + i;
        if (lin < 144) d[i*64 +: 64] = 64'((lin / 12) * 16 + lin % 12);
      end
    end
    return d;
  endfunction

  function automatic logic [63:0] exp_strb(input int b);
    logic [63:0] s;
    int lin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      lin = (b < 2) ? b * 8 + i : (b - 2) * 8 + i;
      if ((b < 2 && lin < 12) || (b >= 2 && lin < 144)) s[i*8 +: 8] = 8'hFF;
    end
    return s;
  endfunction

  task automatic set_pattern();
    for (int k = 0; k < 12; k++) X_in[k] = 64'(k + 1);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) P_in[r][c] = 64'(r * 16 + c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int last_cycles;

  task automatic run_write(input bit corrupt, input string label);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (corrupt) begin
      X_in = '1;
      P_in = '1;
    end
    cyc = 1;
    while (!write_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    last_cycles = cyc;
    check_eq({label, "_done"}, write_done, 1);
    start = 1'b0;
    @(negedge clk);
    check_eq({label, "_done_fall"}, write_done, 0);
    set_pattern();
  endtask

  task automatic check_log(input string label);
    check_eq({label, "_n_aw"}, n_aw, NB);
    check_eq({label, "_n_w"}, n_w, NB);
    for (int b = 0; b < NB && b < n_aw && b < n_w; b++) begin
      check_eq($sformatf("%s_addr%0d", label, b), aw_log[b], exp_addr(b));
      check_eq($sformatf("%s_data%0d", label, b), w_log[b], exp_data(b));
      check_eq($sformatf("%s_strb%0d", label, b), s_log[b], exp_strb(b));
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    set_pattern();
    repeat (3) @(negedge clk);
    check_eq("rst_awvalid", axi_awvalid, 0);
    check_eq("rst_wvalid", axi_wvalid, 0);
    check_eq("rst_bready", axi_bready, 0);
    check_eq("rst_awaddr", axi_awaddr, 0);
    check_eq("rst_wdata", axi_wdata, 0);
    check_eq("rst_wstrb", axi_wstrb, 0);
    check_eq("rst_done", write_done, 0);
    check_eq("rst_error", write_error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("const_fields", {axi_awlen, axi_awsize, axi_awburst, axi_wlast},
             {8'd0, 3'b110, 2'b01, 1'b1});

    // Always-ready slave, clean responses.
    run_write(1'b0, "basic");
    check_eq("basic_latency", last_cycles, 41);
    check_eq("basic_error", write_error, 0);
    check_log("basic");
    check_eq("xb1_lane0", w_log[1][0 +: 64], 64'd9);
    check_eq("xb1_lane3", w_log[1][192 +: 64], 64'd12);
    check_eq("xb1_lane4", w_log[1][256 +: 64], 64'd0);
    check_eq("xb1_strb", s_log[1], 64'h0000_0000_FFFF_FFFF);
    check_eq("pb1_lane0", w_log[3][0 +: 64], 64'd8);
    check_eq("pb1_lane3", w_log[3][192 +: 64], 64'd11);
    check_eq("pb1_lane4", w_log[3][256 +: 64], 64'd16);
    check_eq("pb1_lane7", w_log[3][448 +: 64], 64'd19);
    check_eq("pb1_strb", s_log[3], 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("last_addr", aw_log[19], 32'h0060_0440);

    // Slow address channel, then slow data channel.
    do_reset();
    aw_delay = 3; w_delay = 0;
    run_write(1'b0, "awslow");
    check_log("awslow");
    do_reset();
    aw_delay = 0; w_delay = 3;
    run_write(1'b0, "wslow");
    check_log("wslow");
    aw_delay = 0; w_delay = 0;

    // Inputs trashed one cycle after start; snapshot must be written.
    do_reset();
    run_write(1'b1, "snap");
    check_log("snap");

    // Error response on P beat 5 (overall beat 7).
    do_reset();
    err_beat = 7;
    run_write(1'b0, "err");
    check_eq("err_sticky", write_error, 1);
    check_log("err");

    // Reset during RESP of beat 7, then restart.
    do_reset();
    err_beat = 2;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (!(b_count == 7 && axi_bready) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_resp7", b_count == 7 && axi_bready, 1);
    check_eq("pre_rst_error", write_error, 1);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valids", {axi_awvalid, axi_wvalid, axi_bready}, 0);
    check_eq("mid_rst_done", write_done, 0);
    check_eq("mid_rst_error", write_error, 0);
    rst_n = 1'b1;
    err_beat = 99;
    @(negedge clk);
    run_write(1'b0, "restart");
    check_eq("restart_addr0", aw_log[0], 32'h0050_0000);
    check_eq("restart_error", write_error, 0);
    check_log("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
